trng_conditioner: RTL
=====================

# trng_conditioner

Parametrised conditioning and buffering stage for the ring-oscillator TRNG in the Tiny Tapeout user project. It synchronises NUM_CH raw entropy channels and combines them, with optional von Neumann debiasing. It runs a repetition-count health test, packs the bits into WORD_W-bit words and buffers them in a small FIFO behind a valid/ready handshake. It sits between the oscillator bank and the byte output logic on uo_out.

## Interface
Parameters:
- NUM_CH, 4: number of raw entropy channels (≥1)
- WORD_W, 8: output word width
- FIFO_DEPTH, 4: FIFO entries (power of two, ≥2)
- REP_LIMIT, 16: consecutive identical combined bits that trip the health test (≥2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- ena  in  1  sampling enable; low pauses the bit path, and the FIFO still drains
- raw_bits  in  NUM_CH  asynchronous oscillator outputs
- mode  in  2  00 XOR of all channels raw; 01 XOR + von Neumann; 10 channel 0 raw (test); 11 treated as 01
- clear  in  1  synchronous flush of all state except the synchronisers
- out_data  out  WORD_W  FIFO head word (first-word fall-through)
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head word
- fifo_level  out  $clog2(FIFO_DEPTH+1)  occupied entries
- health_fail  out  1  sticky repetition-test failure
- overflow  out  1  sticky: a completed word was dropped because the FIFO was full

## Operation
- Synchroniser: 2 flops per channel, always clocked (ignores ena/clear). The combined bit c is the XOR of the sync2 outputs (mode 00/01/11) or sync2[0] (mode 10).
- Bit valid: ena=1, health_fail=0, clear=0.
- Health test: runs on c before debiasing in every mode. rep_cnt (reset 0) is set to 1 when c differs from last_c or rep_cnt=0, and otherwise increments. When it reaches REP_LIMIT, health_fail is set. The triggering bit and all later bits are discarded until clear or reset.
- Von Neumann (mode 01/11): pair register holds the first bit of a pair. On the second bit, differing bits emit the first bit; equal bits emit nothing. The pair is then emptied.
- Raw modes: every valid bit is emitted.
- Packer: shift-left, new bit into LSB, so the first bit lands in the MSB. A bit counter counts 0..WORD_W-1. When the WORD_W-th bit arrives, {shift[WORD_W-2:0], bit} is written to the FIFO on the same edge and the counter returns to 0.
- FIFO write when full: the word is dropped and overflow is set. The packer still restarts.
- Pop on out_valid & out_ready. On a simultaneous push and pop while full, both happen, the word is accepted and overflow is not set.
- A change in mode (registered copy compared) flushes the packer, the pair register and rep_cnt on the next edge. The FIFO is kept.
- clear: empties the FIFO and packer, and resets the pair, rep_cnt, health_fail and overflow. It takes priority over push/pop on the same edge.
- Reset mid-word: the partial word is lost and all outputs go to their reset values.

## Timing
- Reset values: out_data 0, out_valid 0, fifo_level 0, health_fail 0, overflow 0. All state registers are 0.
- raw_bits sampled at edge e reaches the packer at edge e+2.
- Raw mode: first bit sampled at e0; the word is written at e(WORD_W+1); out_valid is high from that edge onward. Latency is WORD_W+2 edges.
- Von Neumann mode: latency is data-dependent, at least 2·WORD_W+2 edges.
- out_data is stable while out_valid=1 and out_ready=0.
- Maximum throughput is one word per WORD_W cycles and one pop per cycle.

## Structure
- Package trng_pkg: mode_e enum (MODE_XOR, MODE_VN, MODE_CH0, MODE_RSVD) and the default parameter constants.
- Sub-module trng_fifo: parametrised synchronous FWFT FIFO with push, pop, clear, level, full and empty.
- The synchroniser, health test, debiaser and packer live in trng_conditioner.

## Test plan
- Reset with rst_n low mid-clock: all outputs 0 immediately. After release with ena=0: no words and fifo_level stays 0.
- Mode 00, NUM_CH=4, channels driven so the XOR sequence is 1,0,1,1,0,0,1,0 from e0: out_valid rises after e9 with out_data=0xB2. Popping with out_ready=1 gives fifo_level=0.
- Mode 01, combined pairs (0,1),(1,0),(0,0),(1,1) repeated until 8 emissions: out_data=0x55 and pairs 00/11 emit nothing.
- Constant combined 0 for 16 cycles, REP_LIMIT=16: health_fail=1 after the 16th bit, no further words, and a clear pulse returns health_fail=0 and resumes packing.
- out_ready=0, raw mode, 5 words generated: fifo_level=4, overflow=1, and draining yields the first 4 words in order.
- FIFO full with out_ready=1 on the edge a 5th word completes: the word is accepted, overflow stays 0 and fifo_level stays 4. Asserting rst_n low mid-word then re-running yields a correct first word.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared types and default sizing for the TRNG conditioning path.
package trng_pkg;

  typedef enum logic [1:0] {
    MODE_XOR  = 2'b00,
    MODE_VN   = 2'b01,
    MODE_CH0  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  localparam int NUM_CH_DEF     = 4;
  localparam int WORD_W_DEF     = 8;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int REP_LIMIT_DEF  = 16;

endpackage

// File: rtl/trng_conditioner_if.sv
// Word output handshake between the conditioner and its consumer.
interface trng_conditioner_if
  import trng_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
);
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/trng_fifo.sv
// Small first-word-fall-through FIFO; a pop on a full FIFO frees room for a same-edge push.
module trng_fifo
  import trng_pkg::*;
#(
  parameter int WIDTH = WORD_W_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
)(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  input  logic                         clear,
  output logic [WIDTH-1:0]             head_data,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign full      = (level_q == LVL_W'(DEPTH));
  assign empty     = (level_q == '0);
  assign level     = level_q;
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/trng_conditioner.sv
// Synchronises and combines raw oscillator bits, health-checks and optionally debiases them,
// then packs them MSB-first into words buffered behind a valid/ready FIFO.
module trng_conditioner
  import trng_pkg::*;
#(
  parameter int NUM_CH     = NUM_CH_DEF,
  parameter int WORD_W     = WORD_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int REP_LIMIT  = REP_LIMIT_DEF
)(
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                ena,
  input  logic [NUM_CH-1:0]                   raw_bits,
  input  logic [1:0]                          mode,
  input  logic                                clear,
  trng_conditioner_if.master                  out_if,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level,
  output logic                                health_fail,
  output logic                                overflow
);
  localparam int CNT_W = $clog2(WORD_W);
  localparam int REP_W = $clog2(REP_LIMIT+1);

  logic [NUM_CH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  mode_e             mode_q, mode_d, mode_in;
  logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d, rep_next;
  logic              last_c_q, last_c_d;
  logic              health_fail_q, health_fail_d;
  logic              pair_full_q, pair_full_d, pair_bit_q, pair_bit_d;
  logic [WORD_W-1:0] shift_q, shift_d, push_word;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              overflow_q, overflow_d;
  logic              c_bit, vn_mode, mode_chg, bit_valid;
  logic              emit, emit_bit, push, pop, fifo_full, fifo_empty;

  assign mode_in   = mode_e'(mode);
  assign c_bit     = (mode_in == MODE_CH0) ? sync2_q[0] : ^sync2_q;
  assign vn_mode   = (mode_in == MODE_VN) || (mode_in == MODE_RSVD);
  assign mode_chg  = (mode_in != mode_q);
  assign bit_valid = ena & ~health_fail_q;
  assign push_word = {shift_q[WORD_W-2:0], emit_bit};
  assign pop       = out_if.out_valid & out_if.out_ready;

  always_comb begin
    sync1_d       = raw_bits;
    sync2_d       = sync1_q;
    mode_d        = mode_in;
    rep_cnt_d     = rep_cnt_q;
    last_c_d      = last_c_q;
    health_fail_d = health_fail_q;
    pair_full_d   = pair_full_q;
    pair_bit_d    = pair_bit_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    overflow_d    = overflow_q;
    rep_next      = '0;
    emit          = 1'b0;
    emit_bit      = 1'b0;
    push          = 1'b0;
    if (clear) begin
      rep_cnt_d     = '0;
      last_c_d      = 1'b0;
      health_fail_d = 1'b0;
      pair_full_d   = 1'b0;
      pair_bit_d    = 1'b0;
      shift_d       = '0;
      bit_cnt_d     = '0;
      overflow_d    = 1'b0;
    end else if (mode_chg) begin
      rep_cnt_d   = '0;
      pair_full_d = 1'b0;
      pair_bit_d  = 1'b0;
      shift_d     = '0;
      bit_cnt_d   = '0;
    end else if (bit_valid) begin
      rep_next  = (rep_cnt_q == '0 || c_bit != last_c_q) ? REP_W'(1) : rep_cnt_q + REP_W'(1);
      rep_cnt_d = rep_next;
      last_c_d  = c_bit;
      // The bit that completes the run is itself discarded.
      if (rep_next == REP_W'(REP_LIMIT)) begin
        health_fail_d = 1'b1;
      end else if (vn_mode) begin
        if (!pair_full_q) begin
          pair_full_d = 1'b1;
          pair_bit_d  = c_bit;
        end else begin
          pair_full_d = 1'b0;
          if (pair_bit_q != c_bit) begin
            emit     = 1'b1;
            emit_bit = pair_bit_q;
          end
        end
      end else begin
        emit     = 1'b1;
        emit_bit = c_bit;
      end
      if (emit) begin
        if (bit_cnt_q == CNT_W'(WORD_W-1)) begin
          push      = 1'b1;
          bit_cnt_d = '0;
          shift_d   = '0;
        end else begin
          shift_d   = {shift_q[WORD_W-2:0], emit_bit};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
    end
    if (push && fifo_full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      mode_q        <= MODE_XOR;
      rep_cnt_q     <= '0;
      last_c_q      <= 1'b0;
      health_fail_q <= 1'b0;
      pair_full_q   <= 1'b0;
      pair_bit_q    <= 1'b0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      overflow_q    <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      mode_q        <= mode_d;
      rep_cnt_q     <= rep_cnt_d;
      last_c_q      <= last_c_d;
      health_fail_q <= health_fail_d;
      pair_full_q   <= pair_full_d;
      pair_bit_q    <= pair_bit_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      overflow_q    <= overflow_d;
    end
  end

  trng_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .clear     (clear),
    .head_data (out_if.out_data),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_if.out_valid = ~fifo_empty;
  assign health_fail      = health_fail_q;
  assign overflow         = overflow_q;

endmodule
